keypad_scanner: RTL and testbench

- Scans a 4x3 active-low matrix keypad and debounces the result.
- Produces the 4-bit `key_pad` code consumed by the tone decoder: 0 means no key, 1..12 means key index.
- Sits between the board keypad pins and the tone/PWM path, in the `sys_clk` domain (100 MHz).

---
 rtl/keypad_scanner_pkg.sv | 42 ++++
 rtl/keypad_scanner_key_debouncer.sv | 85 ++++++++
 rtl/keypad_scanner.sv | 94 +++++++++
 tb/tb_keypad_scanner.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_scanner_pkg.sv
`default_nettype none
// ============================================================================
// Module      : keypad_scanner_pkg
// Description : Shared types, widths and helpers for the 4x3 keypad scanner.
//               KEY_NONE/KEY_W describe the key code, NUM_ROWS/NUM_COLS the
//               matrix geometry, row_state_t the row being driven.
// Revision    : 1.0 - initial release
// ============================================================================
package keypad_scanner_pkg;

    localparam int KEY_W    = 4;
    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 3;

    localparam logic [KEY_W-1:0] KEY_NONE = 4'd0;

    typedef enum logic [1:0] {
        ROW0 = 2'd0,
        ROW1 = 2'd1,
        ROW2 = 2'd2,
        ROW3 = 2'd3
    } row_state_t;

    // Code of the lowest pressed key within one row (column 0 wins), or
    // KEY_NONE when no column is pulled low. Codes are row*3 + col + 1.
    function automatic logic [KEY_W-1:0] row_key_code(
        input row_state_t           row,
        input logic [NUM_COLS-1:0]  col_n
    );
        logic [KEY_W-1:0] base;
        base         = {2'b00, row} * 4'd3;
        row_key_code = KEY_NONE;
        if (!col_n[0])
            row_key_code = base + 4'd1;
        else if (!col_n[1])
            row_key_code = base + 4'd2;
        else if (!col_n[2])
            row_key_code = base + 4'd3;
    endfunction

endpackage : keypad_scanner_pkg
`default_nettype wire

// File: rtl/keypad_scanner_key_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : key_debouncer
// Description : Frame-level debouncer. A frame code must repeat for
//               DEBOUNCE_FRAMES consecutive frames before it is committed to
//               o_key_pad; o_key_valid pulses for one cycle when the committed
//               code changes to a nonzero value.
// Ports       : clk, rst (async, active-high)
//               i_frame_end  - one-cycle strobe at the end of each scan frame
//               i_frame_code - lowest pressed key seen during that frame
//               o_key_pad    - committed key code
//               o_key_valid  - new-key pulse
// Config      : KEYPAD_LATCH_EN - when defined, a committed 0 is ignored so the
//               last nonzero key is held.
// Revision    : 1.0 - initial release
// ============================================================================
module key_debouncer
    import keypad_scanner_pkg::*;
#(
    parameter int DEBOUNCE_FRAMES = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_frame_end,
    input  logic [KEY_W-1:0] i_frame_code,
    output logic [KEY_W-1:0] o_key_pad,
    output logic             o_key_valid
);

    localparam int CNT_W = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [CNT_W-1:0] C_FRAMES = CNT_W'(DEBOUNCE_FRAMES);
    localparam logic [CNT_W-1:0] C_ONE    = CNT_W'(1);

    logic [KEY_W-1:0] r_candidate;
    logic [CNT_W-1:0] r_stable;
    logic [KEY_W-1:0] r_key_pad;
    logic             r_key_valid;

    logic [KEY_W-1:0] w_next_cand;
    logic [CNT_W-1:0] w_next_stable;
    logic             w_commit;

    // Next candidate/count are computed first so that the commit decision
    // sees the count including the current frame.
    always_comb begin
        w_next_cand   = r_candidate;
        w_next_stable = r_stable;
        if (i_frame_code == r_candidate) begin
            if (r_stable != C_FRAMES)
                w_next_stable = r_stable + C_ONE;
        end else begin
            w_next_cand   = i_frame_code;
            w_next_stable = C_ONE;
        end
`ifdef KEYPAD_LATCH_EN
        w_commit = i_frame_end && (w_next_stable == C_FRAMES) && (w_next_cand != KEY_NONE);
`else
        w_commit = i_frame_end && (w_next_stable == C_FRAMES);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_candidate <= KEY_NONE;
            r_stable    <= '0;
            r_key_pad   <= KEY_NONE;
            r_key_valid <= 1'b0;
        end else begin
            r_key_valid <= 1'b0;
            if (i_frame_end) begin
                r_candidate <= w_next_cand;
                r_stable    <= w_next_stable;
            end
            if (w_commit) begin
                r_key_pad   <= w_next_cand;
                r_key_valid <= (w_next_cand != r_key_pad) && (w_next_cand != KEY_NONE);
            end
        end
    end

    assign o_key_pad   = r_key_pad;
    assign o_key_valid = r_key_valid;

endmodule : key_debouncer
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module      : keypad_scanner
// Description : Scans a 4x3 active-low matrix keypad one row at a time and
//               debounces the lowest pressed key over whole scan frames.
// Ports       : sys_clk   - system clock
//               sys_rst   - asynchronous active-high reset
//               col_n     - column inputs, active-low, asynchronous
//               row_n     - row drive, one-hot low
//               key_pad   - committed key code, 0 = none, 1..12 = row*3+col+1
//               key_valid - one-cycle pulse on a change to a nonzero key
// Config      : KEYPAD_LATCH_EN - hold the last nonzero key across releases.
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_scanner
    import keypad_scanner_pkg::*;
#(
    parameter int SCAN_DIV        = 100_000,
    parameter int DEBOUNCE_FRAMES = 5
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic [NUM_COLS-1:0] col_n,
    output logic [NUM_ROWS-1:0] row_n,
    output logic [KEY_W-1:0]    key_pad,
    output logic                key_valid
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] C_DWELL_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DIV_W-1:0] C_DWELL_ONE  = DIV_W'(1);

    logic [NUM_COLS-1:0] r_col_meta;
    logic [NUM_COLS-1:0] r_col_sync;
    row_state_t          r_row;
    logic [DIV_W-1:0]    r_dwell;
    logic [NUM_ROWS-1:0] r_row_n;
    logic [KEY_W-1:0]    r_acc;

    logic                w_sample;
    logic                w_frame_end;
    logic [KEY_W-1:0]    w_row_code;
    logic [KEY_W-1:0]    w_frame_code;

    // Sampling at the last dwell cycle leaves room for the one-cycle row
    // drive lag plus the two synchronizer stages (hence SCAN_DIV >= 4).
    always_comb begin
        w_sample     = (r_dwell == C_DWELL_LAST);
        w_frame_end  = w_sample && (r_row == ROW3);
        w_row_code   = row_key_code(r_row, r_col_sync);
        // Earlier rows always hold lower codes, so the accumulator wins.
        w_frame_code = (r_acc != KEY_NONE) ? r_acc : w_row_code;
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_col_meta <= '1;
            r_col_sync <= '1;
            r_row      <= ROW0;
            r_dwell    <= '0;
            r_row_n    <= 4'b1110;
            r_acc      <= KEY_NONE;
        end else begin
            r_col_meta <= col_n;
            r_col_sync <= r_col_meta;
            r_row_n    <= ~(4'b0001 << r_row);
            if (w_sample) begin
                r_dwell <= '0;
                r_row   <= row_state_t'(r_row + 2'd1);
                if (w_frame_end)
                    r_acc <= KEY_NONE;
                else if (r_acc == KEY_NONE)
                    r_acc <= w_row_code;
            end else begin
                r_dwell <= r_dwell + C_DWELL_ONE;
            end
        end
    end

    key_debouncer #(
        .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES)
    ) u_debouncer (
        .clk          (sys_clk),
        .rst          (sys_rst),
        .i_frame_end  (w_frame_end),
        .i_frame_code (w_frame_code),
        .o_key_pad    (key_pad),
        .o_key_valid  (key_valid)
    );

    assign row_n = r_row_n;

endmodule : keypad_scanner
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_keypad_scanner
// Description : Scoreboard bench for keypad_scanner. A keypad matrix model
//               drives col_n from row_n and a pressed-key mask; a frame-level
//               reference model predicts every key_pad change and pushes it
//               into a queue that an independent monitor drains.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_scanner;

    localparam int SD  = 4;
    localparam int DF  = 3;
    localparam int FRM = 4 * SD;
`ifdef KEYPAD_LATCH_EN
    localparam int REL_AFTER_5 = 5;
`else
    localparam int REL_AFTER_5 = 0;
`endif

    localparam logic [11:0] K3  = 12'h004;
    localparam logic [11:0] K5  = 12'h010;
    localparam logic [11:0] K7  = 12'h040;
    localparam logic [11:0] K10 = 12'h200;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic [2:0]  col_n;
    logic [3:0]  row_n;
    logic [3:0]  key_pad;
    logic        key_valid;
    logic [11:0] mask;

    keypad_scanner #(
        .SCAN_DIV        (SD),
        .DEBOUNCE_FRAMES (DF)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .col_n     (col_n),
        .row_n     (row_n),
        .key_pad   (key_pad),
        .key_valid (key_valid)
    );

    always #5 sys_clk = ~sys_clk;

    // Keypad matrix: bit k-1 of mask means key k is pressed.
    always_comb begin
        col_n = 3'b111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 3; c++)
                if (mask[r*3+c] && !row_n[r])
                    col_n[c] = 1'b0;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int code;
        int pulse;
        int cyc;
    } exp_t;

    exp_t        exp_q[$];
    logic [11:0] hist[4096];
    int n = 0;
    int m_acc, m_cand, m_stable, m_key;
    int m_row, m_rc, m_fc;
    logic [11:0] m_seen;

    initial begin
        m_acc = 0; m_cand = 0; m_stable = 0; m_key = 0;
    end

    // The mask driven at the negedge following clock n-3 is what the
    // synchronizer delivers when row ((n-1)/SD)%4 is sampled at clock n.
    always @(posedge sys_clk) begin
        if (sys_rst) begin
            n = 0; m_acc = 0; m_cand = 0; m_stable = 0; m_key = 0;
        end else begin
            n++;
            if (n % SD == 0) begin
                m_row  = ((n - 1) / SD) % 4;
                m_seen = hist[(n - 3) % 4096];
                m_rc   = 0;
                for (int c = 2; c >= 0; c--)
                    if (m_seen[m_row*3+c]) m_rc = m_row * 3 + c + 1;
                if (m_acc == 0) m_acc = m_rc;
                if (m_row == 3) begin
                    m_fc  = m_acc;
                    m_acc = 0;
                    if (m_fc == m_cand) begin
                        if (m_stable < DF) m_stable++;
                    end else begin
                        m_cand   = m_fc;
                        m_stable = 1;
                    end
`ifdef KEYPAD_LATCH_EN
                    if (m_stable == DF && m_cand != 0 && m_cand != m_key) begin
`else
                    if (m_stable == DF && m_cand != m_key) begin
`endif
                        exp_q.push_back('{m_cand, (m_cand != 0) ? 1 : 0, n});
                        m_key = m_cand;
                    end
                end
            end
        end
    end

    // ---------------- monitor ----------------
    logic [3:0] prev_key = 4'd0;
    int pulses = 0;
    int exp_row;
    exp_t e;

    always @(negedge sys_clk) begin
        if (sys_rst) begin
            chk("rst_key_pad", int'(key_pad), 0);
            chk("rst_key_valid", int'(key_valid), 0);
            chk("rst_row_n", int'(row_n), 14);
            prev_key = 4'd0;
        end else begin
            exp_row = (n == 0) ? 0 : ((n - 1) / SD) % 4;
            chk("row_n", int'(row_n), 15 ^ (1 << exp_row));
            if (key_valid) pulses++;
            if (key_pad !== prev_key || key_valid !== 1'b0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output_key_pad", int'(key_pad), int'(prev_key));
                    chk("unexpected_output_key_valid", int'(key_valid), 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_key_pad", int'(key_pad), e.code);
                    chk("sb_key_valid", int'(key_valid), e.pulse);
                    chk("sb_cycle", n, e.cyc);
                end
                prev_key = key_pad;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input logic [11:0] m);
        mask = m;
        hist[n % 4096] = m;
        @(negedge sys_clk);
    endtask

    task automatic hold(input logic [11:0] m, input int cycles);
        for (int i = 0; i < cycles; i++) tick(m);
    endtask

    int p0, sel, len;
    bit bouncy;
    logic [11:0] rm;

    initial begin
        sys_rst = 1'b1;
        mask    = 12'd0;
        hold(12'd0, 3);
        #2 sys_rst = 1'b0;

        // Idle scan: nothing commits
        hold(12'd0, 5 * FRM);
        chk("idle_key_pad", int'(key_pad), 0);
        chk("idle_pulses", pulses, 0);

        // Continuous press of key 5: one pulse only
        p0 = pulses;
        hold(K5, 6 * FRM);
        chk("press5_key_pad", int'(key_pad), 5);
        chk("press5_pulses", pulses - p0, 1);

        hold(12'd0, 5 * FRM);
        chk("release5_key_pad", int'(key_pad), REL_AFTER_5);

        // Bouncing column then steady hold
        for (int i = 0; i < 3 * FRM; i++) tick(((i / 10) % 2 == 0) ? K5 : 12'd0);
        hold(K5, 5 * FRM);
        chk("bounce_then_5", int'(key_pad), 5);

        // Two simultaneous keys: lowest index wins
        hold(12'd0, 5 * FRM);
        hold(K3 | K10, 5 * FRM);
        chk("multi_key_3", int'(key_pad), 3);

        // 5 -> release -> 7
        hold(K5, 5 * FRM);
        chk("seq_5", int'(key_pad), 5);
        hold(12'd0, 4 * FRM);
        chk("seq_release", int'(key_pad), REL_AFTER_5);
        hold(K7, 5 * FRM);
        chk("seq_7", int'(key_pad), 7);

        // Reset mid-frame with key 5 committed
        hold(K5, 5 * FRM + 6);
        chk("pre_rst_5", int'(key_pad), 5);
        #2 sys_rst = 1'b1;
        #1;
        chk("async_rst_key_pad", int'(key_pad), 0);
        chk("async_rst_row_n", int'(row_n), 14);
        hold(K5, 3);
        #2 sys_rst = 1'b0;
        p0 = pulses;
        hold(K5, 5 * FRM);
        chk("post_rst_5", int'(key_pad), 5);
        chk("post_rst_pulse", pulses - p0, 1);

        // Randomized segments
        for (int s = 0; s < 40; s++) begin
            sel = $urandom_range(0, 9);
            if (sel < 3)
                rm = 12'd0;
            else if (sel < 7)
                rm = 12'd1 << $urandom_range(0, 11);
            else
                rm = (12'd1 << $urandom_range(0, 11)) | (12'd1 << $urandom_range(0, 11));
            len    = $urandom_range(8, 72);
            bouncy = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < len; i++)
                tick((bouncy && $urandom_range(0, 3) == 0) ? 12'd0 : rm);
        end

        hold(12'd0, 7 * FRM);
        chk("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_keypad_scanner
`default_nettype wire
